// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: prepends dst/src MAC and EtherType to a payload byte stream and
// serializes it LSB-dibit-first to the RMII MAC. Define FRAMER_DYN_DST_EN for a per-frame dst_mac port.

module eth_tx_framer #(
  parameter logic [47:0] DST_MAC           = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC           = 48'h0200_0000_0002,
  parameter logic [15:0] ETHERTYPE         = 16'h88B5,
  parameter int unsigned MAX_PAYLOAD_BYTES = 1500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        axi_valid,
  output logic [1:0]  axi_dout,
  input  logic        axi_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        err_underrun,
  output logic        err_oversize
`ifdef FRAMER_DYN_DST_EN
  ,
  input  logic [47:0] dst_mac
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_DRAIN,
    S_END
  } state_t;

  localparam logic [10:0] MAX_M1   = 11'(MAX_PAYLOAD_BYTES - 1);
  localparam logic [5:0]  HDR_LAST = 6'd55;

  state_t       state, state_nxt;
  logic         run;
  logic [7:0]   cur_byte, nxt_byte;
  logic         cur_valid, cur_last, nxt_valid, nxt_last;
  logic [5:0]   hdr_cnt;
  logic [1:0]   dib_cnt;
  logic [10:0]  byte_cnt;
  logic [47:0]  frame_dst;
  logic [111:0] hdr_vec;
  logic [6:0]   hdr_bit;
  logic         wr, hs, pop, start, buffered_last;
  logic         flush, set_under, set_over;

  assign wr            = s_valid & s_ready;
  assign hs            = axi_valid & axi_ready;
  assign pop           = (state == S_PAYLOAD) & hs & (dib_cnt == 2'd3);
  assign start         = (state == S_IDLE) & (state_nxt == S_HEADER);
  assign buffered_last = (nxt_valid & nxt_last) | (wr & s_last);

`ifdef FRAMER_DYN_DST_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_dst <= DST_MAC;
    end else if (start) begin
      frame_dst <= dst_mac;
    end
  end
`else
  assign frame_dst = DST_MAC;
`endif

  // Header octets go out MSB octet first, each octet LSB dibit first.
  assign hdr_vec = {frame_dst, SRC_MAC, ETHERTYPE};
  assign hdr_bit = 7'd104 - {hdr_cnt[5:2], 3'b000} + {4'b0000, hdr_cnt[1:0], 1'b0};

  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    axi_valid  = 1'b0;
    axi_dout   = 2'b00;
    busy       = (state != S_IDLE);
    frame_done = 1'b0;
    flush      = 1'b0;
    set_under  = 1'b0;
    set_over   = 1'b0;
    case (state)
      S_IDLE: begin
        s_ready = run & ~nxt_valid;
        if (cur_valid || wr) begin
          state_nxt = S_HEADER;
        end
      end
      S_HEADER: begin
        s_ready   = ~nxt_valid;
        axi_valid = 1'b1;
        axi_dout  = hdr_vec[hdr_bit +: 2];
        if (hs && hdr_cnt == HDR_LAST) begin
          state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        s_ready   = ~nxt_valid;
        axi_valid = 1'b1;
        axi_dout  = cur_byte[{dib_cnt, 1'b0} +: 2];
        // A drain whose terminating last byte is already in hand collapses straight to END.
        if (pop) begin
          if (cur_last) begin
            state_nxt = S_END;
          end else if (byte_cnt == MAX_M1) begin
            set_over  = 1'b1;
            flush     = 1'b1;
            state_nxt = buffered_last ? S_END : S_DRAIN;
          end else if (!nxt_valid) begin
            set_under = 1'b1;
            flush     = 1'b1;
            state_nxt = buffered_last ? S_END : S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          state_nxt = S_END;
        end
      end
      S_END: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      run          <= 1'b0;
      hdr_cnt      <= 6'd0;
      dib_cnt      <= 2'd0;
      byte_cnt     <= 11'd0;
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      state        <= state_nxt;
      run          <= 1'b1;
      err_underrun <= set_under;
      err_oversize <= set_over;
      if (start) begin
        hdr_cnt  <= 6'd0;
        dib_cnt  <= 2'd0;
        byte_cnt <= 11'd0;
      end else begin
        if (state == S_HEADER && hs) begin
          hdr_cnt <= (hdr_cnt == HDR_LAST) ? 6'd0 : hdr_cnt + 6'd1;
        end
        if (state == S_PAYLOAD && hs) begin
          dib_cnt <= dib_cnt + 2'd1;
        end
        if (pop) begin
          byte_cnt <= byte_cnt + 11'd1;
        end
      end
    end
  end

  // Two-entry FIFO: cur is the head being shifted out, nxt the prefetched byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_byte  <= 8'd0;
      cur_last  <= 1'b0;
      cur_valid <= 1'b0;
      nxt_byte  <= 8'd0;
      nxt_last  <= 1'b0;
      nxt_valid <= 1'b0;
    end else if (flush) begin
      cur_valid <= 1'b0;
      nxt_valid <= 1'b0;
    end else if (pop) begin
      if (nxt_valid) begin
        cur_byte  <= nxt_byte;
        cur_last  <= nxt_last;
        cur_valid <= 1'b1;
        nxt_valid <= wr;
        if (wr) begin
          nxt_byte <= s_data;
          nxt_last <= s_last;
        end
      end else begin
        cur_valid <= wr;
        if (wr) begin
          cur_byte <= s_data;
          cur_last <= s_last;
        end
      end
    end else if (wr && state != S_DRAIN) begin
      if (!cur_valid) begin
        cur_byte  <= s_data;
        cur_last  <= s_last;
        cur_valid <= 1'b1;
      end else begin
        nxt_byte  <= s_data;
        nxt_last  <= s_last;
        nxt_valid <= 1'b1;
      end
    end
  end

endmodule
